// File: rtl/sm_pkg.sv
// Shared sign-magnitude definitions: peak-detector state encoding and zero constants.
package sm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } peak_state_t;

    // Sign-magnitude zero of width n: +0 is all zeros, -0 has only the sign bit set.
    function automatic logic [63:0] sm_zero(input int unsigned n, input logic neg);
        return neg ? (64'(1) << (n - 1)) : 64'(0);
    endfunction

    localparam logic [7:0] SM_POS_ZERO = 8'(sm_zero(8, 1'b0));
    localparam logic [7:0] SM_NEG_ZERO = 8'(sm_zero(8, 1'b1));

endpackage

// File: rtl/comparator.sv
// Sign-magnitude ordering primitive: o_out = 1 when i_a >= i_b.
// +0 ranks above -0; equal encodings compare as >=.
module comparator #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_out
);

    logic         w_sa;
    logic         w_sb;
    logic [N-2:0] w_ma;
    logic [N-2:0] w_mb;

    assign w_sa = i_a[N-1];
    assign w_sb = i_b[N-1];
    assign w_ma = i_a[N-2:0];
    assign w_mb = i_b[N-2:0];

    // Differing signs: the positive operand wins. Negatives order by inverted magnitude.
    assign o_out = (w_sa != w_sb) ? ~w_sa
                 : (w_sa ? (w_ma <= w_mb) : (w_ma >= w_mb));

endmodule

// File: rtl/sm_window_peak.sv
// Windowed max/min peak detector for sign-magnitude samples.
// Optional feature macro: SM_PEAK_INDEX_EN adds o_max_idx / o_min_idx window positions.
module sm_window_peak
    import sm_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [N-1:0]  o_max,
    output logic [N-1:0]  o_min,
    output logic          o_valid,
`ifdef SM_PEAK_INDEX_EN
    output logic [((W > 1) ? $clog2(W) : 1)-1:0] o_max_idx,
    output logic [((W > 1) ? $clog2(W) : 1)-1:0] o_min_idx,
`endif
    input  logic          i_ready
);

    localparam int unsigned CW      = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [N-1:0]  ZERO_V   = N'(sm_zero(N, 1'b0));

    peak_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_max;
    logic [N-1:0]  r_min;
    logic          r_ready;
    logic          r_valid;
    logic          w_max_upd;
    logic          w_min_upd;
`ifdef SM_PEAK_INDEX_EN
    logic [CW-1:0] r_max_idx;
    logic [CW-1:0] r_min_idx;
`endif

    comparator #(.N(N)) u_cmp_max (
        .i_a   (i_data),
        .i_b   (r_max),
        .o_out (w_max_upd)
    );

    comparator #(.N(N)) u_cmp_min (
        .i_a   (r_min),
        .i_b   (i_data),
        .o_out (w_min_upd)
    );

    // Window FSM: collects W samples, then holds the extremes until the consumer takes them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_max     <= ZERO_V;
            r_min     <= ZERO_V;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
`ifdef SM_PEAK_INDEX_EN
            r_max_idx <= '0;
            r_min_idx <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_max     <= i_data;
                        r_min     <= i_data;
`ifdef SM_PEAK_INDEX_EN
                        r_max_idx <= '0;
                        r_min_idx <= '0;
`endif
                        if (W == 1) begin
                            r_state <= HOLD;
                            r_ready <= 1'b0;
                            r_valid <= 1'b1;
                        end else begin
                            r_cnt   <= CW'(1);
                            r_state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (i_valid) begin
                        if (w_max_upd) begin
                            r_max     <= i_data;
`ifdef SM_PEAK_INDEX_EN
                            r_max_idx <= r_cnt;
`endif
                        end
                        if (w_min_upd) begin
                            r_min     <= i_data;
`ifdef SM_PEAK_INDEX_EN
                            r_min_idx <= r_cnt;
`endif
                        end
                        // Last sample parks the counter at W-1 instead of wrapping.
                        if (r_cnt == CNT_LAST) begin
                            r_state <= HOLD;
                            r_ready <= 1'b0;
                            r_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_max   = r_max;
    assign o_min   = r_min;
`ifdef SM_PEAK_INDEX_EN
    assign o_max_idx = r_max_idx;
    assign o_min_idx = r_min_idx;
`endif

endmodule

// File: tb/tb_sm_window_peak.sv
// Self-checking bench for sm_window_peak (W=4 main instance, W=1 secondary instance).
module tb_sm_window_peak;
    import sm_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d4, d1;
    logic       v4, v1, r4, r1;
    logic       rdy4, rdy1, val4, val1;
    logic [7:0] max4, min4, max1, min1;
`ifdef SM_PEAK_INDEX_EN
    logic [1:0] mxi4, mni4;
    logic [0:0] mxi1, mni1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sm_window_peak #(.N(8), .W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(d4), .i_valid(v4), .o_ready(rdy4),
        .o_max(max4), .o_min(min4), .o_valid(val4),
`ifdef SM_PEAK_INDEX_EN
        .o_max_idx(mxi4), .o_min_idx(mni4),
`endif
        .i_ready(r4)
    );

    sm_window_peak #(.N(8), .W(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_data(d1), .i_valid(v1), .o_ready(rdy1),
        .o_max(max1), .o_min(min1), .o_valid(val1),
`ifdef SM_PEAK_INDEX_EN
        .o_max_idx(mxi1), .o_min_idx(mni1),
`endif
        .i_ready(r1)
    );

    typedef struct packed {
        logic [31:0] smp;   // first sample in the top byte
        logic [7:0]  emax;
        logic [7:0]  emin;
        logic [1:0]  imax;
        logic [1:0]  imin;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ordering rank as a plain signed number: -0 sits between +0 and -1.
    function automatic int rank(input logic [7:0] x);
        return x[7] ? -int'(x[6:0]) - 1 : int'(x[6:0]);
    endfunction

    // Reference extremes over a window; ties go to the later sample.
    task automatic ref_peak(input logic [7:0] s[$], output logic [7:0] mx, output logic [7:0] mn,
                            output int ix, output int in_);
        mx = s[0]; mn = s[0]; ix = 0; in_ = 0;
        for (int i = 1; i < s.size(); i++) begin
            if (rank(s[i]) >= rank(mx)) begin mx = s[i]; ix = i; end
            if (rank(s[i]) <= rank(mn)) begin mn = s[i]; in_ = i; end
        end
    endtask

    // Stream one 4-sample window back-to-back, then take the result immediately.
    task automatic run_window(input vec_t t, input string tag);
        logic [31:0] s;
        s = t.smp;
        r4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_ready"}, 32'(rdy4), 32'd1);
            chk({tag, "_novalid"}, 32'(val4), 32'd0);
            v4 = 1'b1;
            d4 = s[31 - 8*k -: 8];
            tick();
        end
        v4 = 1'b0;
        chk({tag, "_valid"}, 32'(val4), 32'd1);
        chk({tag, "_busy"}, 32'(rdy4), 32'd0);
        chk({tag, "_max"}, 32'(max4), 32'(t.emax));
        chk({tag, "_min"}, 32'(min4), 32'(t.emin));
`ifdef SM_PEAK_INDEX_EN
        chk({tag, "_max_idx"}, 32'(mxi4), 32'(t.imax));
        chk({tag, "_min_idx"}, 32'(mni4), 32'(t.imin));
`endif
        tick();
        chk({tag, "_valid_drop"}, 32'(val4), 32'd0);
        chk({tag, "_ready_back"}, 32'(rdy4), 32'd1);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] emx, emn;
        int         eix, ein;
        logic       m_hold;
        int         windows, cycles;
        logic       v, r;
        logic [7:0] d;

        tbl[0] = '{32'h03870982, 8'h09, 8'h87, 2'd2, 2'd1};
        tbl[1] = '{32'h00808000, SM_POS_ZERO, SM_NEG_ZERO, 2'd3, 2'd2};
        tbl[2] = '{32'h85858585, 8'h85, 8'h85, 2'd3, 2'd3};
        tbl[3] = '{32'h01020304, 8'h04, 8'h01, 2'd3, 2'd0};
        tbl[4] = '{32'h05850585, 8'h05, 8'h85, 2'd2, 2'd3};
        tbl[5] = '{32'h7F00FF80, 8'h7F, 8'hFF, 2'd0, 2'd2};

        rst = 1'b1; v4 = 0; v1 = 0; r4 = 0; r1 = 0; d4 = 0; d1 = 0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_ready", 32'(rdy4), 32'd1);
        chk("rst_valid", 32'(val4), 32'd0);
        chk("rst_max", 32'(max4), 32'h00);
        chk("rst_min", 32'(min4), 32'h00);
        chk("rst_ready_w1", 32'(rdy1), 32'd1);

        for (int i = 0; i < 6; i++) run_window(tbl[i], $sformatf("tbl%0d", i));

        // Result held while consumer stalls; offered sample must be refused.
        r4 = 1'b0;
        for (int k = 0; k < 4; k++) begin v4 = 1'b1; d4 = 8'h85; tick(); end
        d4 = 8'h11;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(val4), 32'd1);
            chk("stall_ready", 32'(rdy4), 32'd0);
            chk("stall_max", 32'(max4), 32'h85);
            tick();
        end
        r4 = 1'b1;
        tick();
        chk("stall_release_valid", 32'(val4), 32'd0);
        chk("stall_release_ready", 32'(rdy4), 32'd1);
        chk("stall_not_taken", 32'(max4), 32'h85);
        tick();
        chk("stall_next_accept", 32'(max4), 32'h11);
        for (int k = 0; k < 3; k++) tick();
        v4 = 1'b0;
        chk("stall_w2_valid", 32'(val4), 32'd1);
        chk("stall_w2_min", 32'(min4), 32'h11);
        tick();

        // Reset mid-window discards the partial result.
        for (int k = 0; k < 2; k++) begin v4 = 1'b1; d4 = 8'h7F; tick(); end
        chk("pre_rst_max", 32'(max4), 32'h7F);
        v4 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(val4), 32'd0);
        chk("midrst_ready", 32'(rdy4), 32'd1);
        chk("midrst_max", 32'(max4), 32'h00);
        chk("midrst_min", 32'(min4), 32'h00);
        run_window(tbl[3], "post_rst");

        // W = 1 instance: every sample is a full window.
        v1 = 1'b1; d1 = 8'hFF; r1 = 1'b0;
        tick();
        chk("w1_a_valid", 32'(val1), 32'd1);
        chk("w1_a_max", 32'(max1), 32'hFF);
        chk("w1_a_min", 32'(min1), 32'hFF);
        d1 = 8'h7F; r1 = 1'b1;
        tick();
        chk("w1_a_drop", 32'(val1), 32'd0);
        chk("w1_a_ready", 32'(rdy1), 32'd1);
        chk("w1_a_hold_max", 32'(max1), 32'hFF);
        tick();
        v1 = 1'b0;
        chk("w1_b_valid", 32'(val1), 32'd1);
        chk("w1_b_max", 32'(max1), 32'h7F);
        chk("w1_b_min", 32'(min1), 32'h7F);
`ifdef SM_PEAK_INDEX_EN
        chk("w1_b_idx", 32'(mxi1), 32'd0);
`endif
        tick();
        chk("w1_b_drop", 32'(val1), 32'd0);

        // Random handshake gaps against the reference model.
        m_hold = 1'b0; windows = 0; cycles = 0;
        q.delete();
        emx = '0; emn = '0; eix = 0; ein = 0;
        while (windows < 1000 && cycles < 40000) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            v4 = v; r4 = r; d4 = d;
            tick();
            cycles++;
            if (!m_hold) begin
                if (v) q.push_back(d);
                if (q.size() == 4) begin
                    ref_peak(q, emx, emn, eix, ein);
                    q.delete();
                    m_hold = 1'b1;
                end
            end else if (r) begin
                m_hold = 1'b0;
                windows++;
            end
            chk("rnd_valid", 32'(val4), 32'(m_hold));
            chk("rnd_ready", 32'(rdy4), 32'(!m_hold));
            if (m_hold) begin
                chk("rnd_max", 32'(max4), 32'(emx));
                chk("rnd_min", 32'(min4), 32'(emn));
`ifdef SM_PEAK_INDEX_EN
                chk("rnd_max_idx", 32'(mxi4), 32'(eix));
                chk("rnd_min_idx", 32'(mni4), 32'(ein));
`endif
            end
        end
        chk("rnd_windows_done", 32'(windows), 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_window_peak.md
# sm_window_peak

Streaming peak detector for N-bit sign-magnitude samples. It accepts samples over a valid/ready handshake, tracks the running maximum and minimum over a fixed window of W samples, then presents both extremes over a second valid/ready handshake. It sits directly downstream of the signed-magnitude compare logic and uses the team's `comparator` block (`o_out` = 1 when a ≥ b) as its ordering primitive.

## Interface
- `N`, default 8: sample width; bit N-1 is the sign (1 = negative), bits N-2:0 are the magnitude.
- `W`, default 4: samples per window, ≥ 1.
- `CW`, default `$clog2(W)` with a minimum of 1: sample-counter width. This is a localparam.
- Clocking and reset (already decided): one clock, `i_clk`; `i_rst` is synchronous and active-high.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_data`  in  N  input sample.
- `i_valid`  in  1  `i_data` is valid.
- `o_ready`  out  1  block accepts a sample this cycle.
- `o_max`  out  N  window maximum.
- `o_min`  out  N  window minimum.
- `o_valid`  out  1  `o_max` and `o_min` hold a completed window.
- `i_ready`  in  1  consumer takes the result.

## Operation
- A sample is accepted on any cycle where `i_valid && o_ready`.
- FSM states:
  - IDLE: `o_ready` = 1. On accept, load `max_r` and `min_r` with `i_data` and set cnt = 1. If W == 1, go to HOLD; otherwise go to ACC.
  - ACC: `o_ready` = 1. On accept, update the extremes and increment cnt. When the accepted sample is the W-th, go to HOLD.
  - HOLD: `o_ready` = 0 and `o_valid` = 1. When `i_ready` = 1, go to IDLE.
- Ordering uses comparator semantics only:
  - Max update: `cmp(i_data, max_r)` = 1 → `max_r` ← `i_data`.
  - Min update: `cmp(min_r, i_data)` = 1 → `min_r` ← `i_data`.
  - On a tie, the latest sample wins.
- Zero handling: +0 (0x00) ranks above −0 (0x80). Zeros are not normalised.
- The max and min updates for one sample happen in the same cycle, using two comparator instances.
- `o_max` and `o_min` come straight from registers. They are stable throughout HOLD, and in IDLE/ACC they show the partial window.
- `i_valid` is ignored while `o_ready` = 0, and `i_ready` is ignored outside HOLD.
- Sample input and result output never handshake in the same cycle.
- A new window starts only in the cycle after the result handshake.
- Reset mid-window or during HOLD discards everything, with no partial result emitted.

## Timing
- Reset values:
  - state = IDLE, cnt = 0.
  - `o_ready` = 1, `o_valid` = 0.
  - `o_max` = 0x00, `o_min` = 0x00.
- `o_valid` rises in the cycle after the W-th accept, so latency is 1 cycle from the last sample to the result.
- `o_valid` drops in the cycle after the handshake. `o_ready` returns to 1 in that same cycle.
- Peak throughput: one window per W+1 cycles when `i_ready` is held at 1.
- Counter: cnt runs 0..W-1 and never wraps within a window. It clears on entry to IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SM_PEAK_INDEX_EN` defined:
  - Adds outputs `o_max_idx` [CW-1:0] and `o_min_idx` [CW-1:0], the window position (0-based) of the reported extreme.
  - The index follows the latest-wins tie rule.
  - Both indices reset to 0, and are loaded with 0 on the first sample of a window.
- Not defined: the index ports and their registers do not exist. All other behaviour is identical.

## Structure
- Shared package `sm_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACC, HOLD} peak_state_t`.
  - Sign-magnitude helper constants: `SM_POS_ZERO` = 0x00, `SM_NEG_ZERO` = 0x80 for N = 8 (parameterised function form).
- Sub-module: two instances of the existing `comparator` (`u_cmp_max`, `u_cmp_min`), with parameter N passed through.
- No other sub-module.

## Test plan
- W = 4, samples 0x03, 0x87, 0x09, 0x82, `i_ready` = 1 → `o_max` = 0x09 (+9), `o_min` = 0x87 (−7), `o_valid` for exactly 1 cycle, 1 cycle after the 4th accept.
- W = 4, samples 0x00, 0x80, 0x80, 0x00 with `SM_PEAK_INDEX_EN` → `o_max` = 0x00 with `o_max_idx` = 3; `o_min` = 0x80 with `o_min_idx` = 2.
- W = 4, all samples 0x85, then `i_ready` held at 0 for 5 cycles → `o_valid` held high, `o_ready` = 0, and a 5th sample offered with `i_valid` = 1 is not accepted. After `i_ready` = 1, the next sample is accepted one cycle later.
- W = 4, reset asserted after 2 accepts of 0x7F → next cycle `o_valid` = 0, `o_ready` = 1, `o_max` = `o_min` = 0x00. A new window 0x01, 0x02, 0x03, 0x04 yields `o_max` = 0x04, `o_min` = 0x01.
- W = 1, samples 0xFF then 0x7F, `i_ready` = 1 → two results, (0xFF, 0xFF) then (0x7F, 0x7F), each valid for one cycle, with the second sample accepted the cycle after the first handshake.
- Random back-to-back `i_valid`/`i_ready` gaps, 1000 windows, W = 4, N = 8 → results match a signed-integer reference model (with +0 > −0 and latest-wins ties).
